seq_floor_divider: RTL and testbench

- Multi-cycle unsigned floor divider. It replaces the single-cycle combinational "/" in the CPU's divide execute state.
- The CPU latches the dividend (operand A) and the divisor (second operand read from RAM), pulses start, and stalls until done. It then writes quotient back to RAM.
- Restoring shift-subtract algorithm, one quotient bit per clock. This keeps the 32-bit divide off the RAM-address-to-write-data critical path.

---
 rtl/seq_floor_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_floor_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_floor_divider.sv
// seq_floor_divider: multi-cycle unsigned floor divider (restoring
// shift-subtract, one quotient bit per clock).
//
// Optional build macro: SEQ_DIV_ZERO_FLAG_EN
//   When defined, a div_zero output is added.  A divisor of zero then
//   completes in a single cycle: quotient = all ones, remainder = dividend,
//   and div_zero = 1.
//   When undefined, a zero divisor runs the full WIDTH iterations and
//   produces the same quotient and remainder.
//
// Results are held on quotient/remainder from the DONE cycle until the
// next accepted start.  While busy is high they show work in progress.
`timescale 1ns/1ps

module seq_floor_divider #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The counter value seen on the edge that performs the last iteration.
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    // One restoring iteration: shift {rem, q} left, trial-subtract the
    // divisor, and keep the difference only if it did not go negative.
    // The subtraction is carried one bit wider than the remainder so the
    // borrow is a separate sign bit.  Returns {rem_next, q_next}.
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [2*WIDTH+1:0] shifted;
        logic [WIDTH+1:0]   trial;
        shifted = {rem, q, 1'b0};
        trial   = shifted[2*WIDTH+1:WIDTH] - {2'b00, d};
        if (trial[WIDTH+1] == 1'b0) begin
            div_step = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            div_step = {shifted[2*WIDTH:WIDTH], shifted[WIDTH-1:0]};
        end
    endfunction

    state_t           state_r;
    state_t           state_n;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH-1:0] dvsr_n;
    logic [CNTW-1:0]  cnt_r;
    logic [CNTW-1:0]  cnt_n;
    logic             busy_r;
    logic             busy_n;
    logic             done_r;
    logic             done_n;
    logic [2*WIDTH:0] step_s;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic             dz_r;
    logic             dz_n;
`endif

    // Datapath for one iteration, evaluated from the current registers.
    always_comb begin
        step_s = div_step(rem_r, q_r, dvsr_r);
    end

    // Next-state and next-register logic; outputs are decoded from the
    // next state so busy/done come straight out of flops.
    always_comb begin
        state_n = state_r;
        rem_n   = rem_r;
        q_n     = q_r;
        dvsr_n  = dvsr_r;
        cnt_n   = cnt_r;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        dz_n    = dz_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start == 1'b1) begin
                    // Dividend enters the quotient shift register; its bits
                    // are shifted out into the partial remainder one per
                    // iteration while quotient bits shift in from the right.
                    q_n     = dividend;
                    dvsr_n  = divisor;
                    rem_n   = '0;
                    cnt_n   = '0;
                    state_n = ST_RUN;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                    if (divisor == '0) begin
                        q_n     = '1;
                        rem_n   = {1'b0, dividend};
                        state_n = ST_DONE;
                        dz_n    = 1'b1;
                    end else begin
                        dz_n    = 1'b0;
                    end
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_n = step_s[2*WIDTH:WIDTH];
                q_n   = step_s[WIDTH-1:0];
                cnt_n = cnt_r + CNT_ONE;
                if (cnt_r == LAST_CNT) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                rem_n   = '0;
                q_n     = '0;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n == ST_RUN);
        done_n = (state_n == ST_DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= '0;
            q_r     <= '0;
            dvsr_r  <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            dz_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            rem_r   <= rem_n;
            q_r     <= q_n;
            dvsr_r  <= dvsr_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            dz_r    <= dz_n;
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = q_r;
    assign remainder = rem_r[WIDTH-1:0];
`ifdef SEQ_DIV_ZERO_FLAG_EN
    assign div_zero  = dz_r;
`endif

endmodule

// File: tb/tb_seq_floor_divider.sv
// Testbench for seq_floor_divider.  A behavioural model predicts, for each
// cycle, whether the divider is busy or done and what results it holds,
// using plain '/' and '%' and the accept-edge cycle number.  A negedge
// process compares the DUT against it every cycle; directed cases add
// literal expectations.
`timescale 1ns/1ps

module tb_seq_floor_divider;

    localparam int W = 32;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic         div_zero;
`endif

    seq_floor_divider #(.WIDTH(W), .CNTW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef SEQ_DIV_ZERO_FLAG_EN
        .div_zero  (div_zero),
`endif
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;

    // Model state: cycle number, and the cycle in which done is due.
    int           ecnt = 0;
    int           m_done_at = 0;
    bit           m_active = 1'b0;
    bit           m_known = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    bit           m_dz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] b);
        return (ZF && b == '0) ? 0 : W;
    endfunction

    // Reference model: an operation accepted at an edge is due W cycles later
    // (or immediately for a flagged zero divisor); results by plain arithmetic.
    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (rst) begin
            m_known   <= 1'b1;
            m_active  <= 1'b0;
            m_q       <= '0;
            m_r       <= '0;
            m_dz      <= 1'b0;
        end else if (start && !(m_active && ecnt < m_done_at)) begin
            m_active  <= 1'b1;
            m_done_at <= ecnt + 1 + lat_of(divisor);
            m_q       <= (divisor == '0) ? {W{1'b1}} : dividend / divisor;
            m_r       <= (divisor == '0) ? dividend : dividend % divisor;
            m_dz      <= ZF && (divisor == '0);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", {63'd0, busy}, {63'd0, m_active && ecnt < m_done_at});
            chk("done", {63'd0, done}, {63'd0, m_active && ecnt == m_done_at});
            if (!(m_active && ecnt < m_done_at)) begin
                chk("quotient", {32'd0, quotient}, {32'd0, m_q});
                chk("remainder", {32'd0, remainder}, {32'd0, m_r});
            end
`ifdef SEQ_DIV_ZERO_FLAG_EN
            chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        edges    = 0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && edges < 200) tick();
        chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int gap;
        int seen;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_q", {32'd0, quotient}, 64'd0);
        chk("reset_r", {32'd0, remainder}, 64'd0);

        // Basic divide
        start_op(32'd100, 32'd9);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done();
        chk("lat_100_9", edges, 64'd32);
        chk("q_100_9", {32'd0, quotient}, 64'd11);
        chk("r_100_9", {32'd0, remainder}, 64'd1);
        chk("model_q_100_9", {32'd0, m_q}, 64'd11);

        // Back-to-back from the DONE cycle, with ignored starts during RUN
        start_op(32'd1000, 32'd10);
        dividend = 32'd7;
        divisor  = 32'd1;
        start    = 1'b1;
        repeat (3) tick();
        start    = 1'b0;
        wait_done();
        chk("lat_b2b", edges, 64'd32);
        chk("q_1000_10", {32'd0, quotient}, 64'd100);
        chk("r_1000_10", {32'd0, remainder}, 64'd0);

        // Edge operands
        tick();
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done();
        chk("q_max_1", {32'd0, quotient}, 64'hFFFF_FFFF);
        chk("r_max_1", {32'd0, remainder}, 64'd0);
        start_op(32'd5, 32'd7);
        wait_done();
        chk("q_5_7", {32'd0, quotient}, 64'd0);
        chk("r_5_7", {32'd0, remainder}, 64'd5);
        chk("lat_5_7", edges, 64'd32);
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_done();
        chk("q_msb", {32'd0, quotient}, 64'd1);
        chk("r_msb", {32'd0, remainder}, 64'd0);

        // Divide by zero
        tick();
        start_op(32'd42, 32'd0);
        wait_done();
        chk("q_42_0", {32'd0, quotient}, 64'hFFFF_FFFF);
        chk("r_42_0", {32'd0, remainder}, 64'd42);
        chk("model_r_42_0", {32'd0, m_r}, 64'd42);
`ifdef SEQ_DIV_ZERO_FLAG_EN
        chk("lat_42_0", edges, 64'd0);
        chk("dz_set", {63'd0, div_zero}, 64'd1);
        start_op(32'd9, 32'd3);
        wait_done();
        chk("dz_clear", {63'd0, div_zero}, 64'd0);
        chk("q_9_3", {32'd0, quotient}, 64'd3);
`else
        chk("lat_42_0", edges, 64'd32);
`endif

        // Reset mid-operation
        tick();
        start_op(32'd100, 32'd9);
        while (edges < 15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_q", {32'd0, quotient}, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("no_done_after_rst", seen, 64'd0);

        // Randomized pairs, nonzero divisor
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            start_op(a, b);
            dividend = $urandom;
            divisor  = $urandom;
            wait_done();
            chk("rand_lat", edges, 64'd32);
            chk("rand_q", {32'd0, quotient}, {32'd0, a / b});
            chk("rand_r", {32'd0, remainder}, {32'd0, a % b});
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
